// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: combinational reads, committed writes, trap/mret
// bookkeeping and free-running cycle/instret counters.
module csr_regfile #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     HART_ID  = 0,
    parameter logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_rillegal,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_wvalid,
    input  logic            instret_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_valid_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_global_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mcycle_q;
    logic [XLEN-1:0] minstret_q;
    logic [XLEN-1:0] mstatus_rd;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[3]     = mstatus_mie_q;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[12:11] = 2'b11;
    end

    always_comb begin
        csr_rdata    = '0;
        csr_rillegal = 1'b0;
        case (csr_raddr)
            ADDR_MSTATUS:              csr_rdata = mstatus_rd;
            ADDR_MISA:                 csr_rdata = MISA_VAL;
            ADDR_MIE:                  csr_rdata = mie_q;
            ADDR_MTVEC:                csr_rdata = mtvec_q;
            ADDR_MSCRATCH:             csr_rdata = mscratch_q;
            ADDR_MEPC:                 csr_rdata = mepc_q;
            ADDR_MCAUSE:               csr_rdata = mcause_q;
            ADDR_MTVAL:                csr_rdata = mtval_q;
            ADDR_MCYCLE, ADDR_CYCLE:   csr_rdata = mcycle_q;
            ADDR_MINSTRET, ADDR_INSTRET: csr_rdata = minstret_q;
            ADDR_MHARTID:              csr_rdata = XLEN'(HART_ID);
            default:                   csr_rillegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            // A software write to a counter replaces that cycle's increment.
            if (csr_wvalid && csr_waddr == ADDR_MCYCLE) begin
                mcycle_q <= csr_wdata;
            end else begin
                mcycle_q <= mcycle_q + 1'b1;
            end

            if (csr_wvalid && csr_waddr == ADDR_MINSTRET) begin
                minstret_q <= csr_wdata;
            end else if (instret_i) begin
                minstret_q <= minstret_q + 1'b1;
            end

            if (csr_wvalid) begin
                case (csr_waddr)
                    ADDR_MIE:      mie_q      <= csr_wdata;
                    ADDR_MTVEC:    mtvec_q    <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
                    ADDR_MSCRATCH: mscratch_q <= csr_wdata;
                    default:       ;
                endcase
            end

            // Trap beats mret; both beat software writes to the trap-owned CSRs.
            if (trap_valid_i) begin
                mepc_q         <= {trap_pc_i[XLEN-1:2], 2'b00};
                mcause_q       <= trap_cause_i;
                mtval_q        <= trap_tval_i;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_valid_i) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (csr_wvalid) begin
                case (csr_waddr)
                    ADDR_MSTATUS: begin
                        mstatus_mie_q  <= csr_wdata[3];
                        mstatus_mpie_q <= csr_wdata[7];
                    end
                    ADDR_MEPC:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: mcause_q <= csr_wdata;
                    ADDR_MTVAL:  mtval_q  <= csr_wdata;
                    default:     ;
                endcase
            end
        end
    end

    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    assign mie_global_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset, decode, masking, counters, trap/mret priority,
// and asynchronous reset in the middle of a write.
module tb_csr_regfile;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned HART_ID = 3;
    localparam logic [63:0] MISA    = 64'h8000_0000_0000_0100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [11:0]     csr_raddr = '0;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_rillegal;
    logic [11:0]     csr_waddr = '0;
    logic [XLEN-1:0] csr_wdata = '0;
    logic            csr_wvalid = 1'b0;
    logic            instret_i = 1'b0;
    logic            trap_valid_i = 1'b0;
    logic [XLEN-1:0] trap_cause_i = '0;
    logic [XLEN-1:0] trap_pc_i = '0;
    logic [XLEN-1:0] trap_tval_i = '0;
    logic            mret_valid_i = 1'b0;
    logic [XLEN-1:0] mtvec_o;
    logic [XLEN-1:0] mepc_o;
    logic            mie_global_o;

    int checks = 0;
    int errors = 0;

    always #50 clk = ~clk;

    csr_regfile #(
        .XLEN    (XLEN),
        .HART_ID (HART_ID),
        .MISA_VAL(MISA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_rillegal(csr_rillegal),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .csr_wvalid  (csr_wvalid),
        .instret_i   (instret_i),
        .trap_valid_i(trap_valid_i),
        .trap_cause_i(trap_cause_i),
        .trap_pc_i   (trap_pc_i),
        .trap_tval_i (trap_tval_i),
        .mret_valid_i(mret_valid_i),
        .mtvec_o     (mtvec_o),
        .mepc_o      (mepc_o),
        .mie_global_o(mie_global_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr_raddr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [63:0] data);
        csr_waddr  = addr;
        csr_wdata  = data;
        csr_wvalid = 1'b1;
    endtask

    // Advance past one rising edge, then drop all single-cycle strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        csr_wvalid   = 1'b0;
        trap_valid_i = 1'b0;
        mret_valid_i = 1'b0;
        instret_i    = 1'b0;
    endtask

    initial begin
        // Held in reset: everything zero, counters frozen.
        #20;
        check("rst_mtvec_o", mtvec_o, 64'h0);
        check("rst_mepc_o", mepc_o, 64'h0);
        check("rst_mie_global", {63'h0, mie_global_o}, 64'h0);
        wr(12'h340, 64'h77);
        tick();
        tick();
        rd("rst_mcycle_frozen", 12'hB00, 64'h0);
        rd("rst_mscratch", 12'h340, 64'h0);
        rd("rst_mstatus", 12'h300, 64'h1800);

        rst = 1'b0;
        rd("mcycle_first", 12'hB00, 64'h0);
        tick();
        rd("mcycle_second", 12'hB00, 64'h1);
        rd("cycle_alias", 12'hC00, 64'h1);

        rd("misa", 12'h301, MISA);
        rd("mhartid", 12'hF14, 64'h3);
        rd("illegal_rdata", 12'h7C0, 64'h0);
        check("illegal_flag", {63'h0, csr_rillegal}, 64'h1);
        rd("legal_rdata_mtvec", 12'h305, 64'h0);
        check("legal_flag", {63'h0, csr_rillegal}, 64'h0);

        // mtvec bit 1 cleared; same-cycle read sees old value.
        wr(12'h305, 64'hFFF);
        rd("mtvec_no_fwd", 12'h305, 64'h0);
        tick();
        rd("mtvec_masked", 12'h305, 64'hFFD);
        check("mtvec_o", mtvec_o, 64'hFFD);

        wr(12'hF14, 64'h5);
        tick();
        rd("mhartid_ro", 12'hF14, 64'h3);
        wr(12'h301, 64'h0);
        tick();
        rd("misa_ro", 12'h301, MISA);
        wr(12'h7C0, 64'h1234);
        tick();
        rd("unimpl_write", 12'h7C0, 64'h0);

        wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd("mstatus_all_ones", 12'h300, 64'h1888);
        check("mie_global_set", {63'h0, mie_global_o}, 64'h1);
        wr(12'h300, 64'h8);
        tick();
        rd("mstatus_mie_only", 12'h300, 64'h1808);

        wr(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd("mie_full", 12'h304, 64'hFFFF_FFFF_FFFF_FFFF);

        // Counter write wins over increment; wrap at all-ones.
        wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd("mcycle_all_ones", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd("mcycle_wrap", 12'hB00, 64'h0);

        wr(12'hB02, 64'h10);
        instret_i = 1'b1;
        tick();
        rd("minstret_write_wins", 12'hB02, 64'h10);
        instret_i = 1'b1;
        tick();
        rd("minstret_inc", 12'hB02, 64'h11);
        tick();
        rd("instret_alias_hold", 12'hC02, 64'h11);

        // Trap beats a coincident mepc write.
        trap_valid_i = 1'b1;
        trap_pc_i    = 64'h8000_0006;
        trap_cause_i = 64'd11;
        trap_tval_i  = 64'h123;
        wr(12'h341, 64'h40);
        tick();
        rd("trap_mepc", 12'h341, 64'h8000_0004);
        check("trap_mepc_o", mepc_o, 64'h8000_0004);
        rd("trap_mcause", 12'h342, 64'd11);
        rd("trap_mtval", 12'h343, 64'h123);
        rd("trap_mstatus", 12'h300, 64'h1880);
        check("trap_mie_global", {63'h0, mie_global_o}, 64'h0);

        mret_valid_i = 1'b1;
        tick();
        rd("mret_mstatus", 12'h300, 64'h1888);

        // Trap and mret together: trap only; mscratch write still lands.
        trap_valid_i = 1'b1;
        mret_valid_i = 1'b1;
        trap_pc_i    = 64'h200;
        trap_cause_i = 64'd2;
        wr(12'h340, 64'hAB);
        tick();
        rd("both_mstatus", 12'h300, 64'h1880);
        rd("both_mscratch", 12'h340, 64'hAB);
        rd("both_mepc", 12'h341, 64'h200);
        rd("both_mcause", 12'h342, 64'd2);

        // Asynchronous reset between edges during a mscratch write.
        wr(12'h340, 64'h55);
        #10;
        rst = 1'b1;
        #1;
        rd("async_mscratch", 12'h340, 64'h0);
        check("async_mtvec_o", mtvec_o, 64'h0);
        check("async_mepc_o", mepc_o, 64'h0);
        rd("async_mcause", 12'h342, 64'h0);
        rd("async_minstret", 12'hB02, 64'h0);
        tick();
        rst = 1'b0;
        rd("post_rst_mscratch", 12'h340, 64'h0);
        rd("post_rst_mstatus", 12'h300, 64'h1800);
        rd("post_rst_mcycle", 12'hB00, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-003 SHALL have parameter MISA_VAL, default 64'h8000_0000_0000_0100 (RV64I), value returned by misa.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port csr_raddr  in  12  read address from the CSR functional unit.
REQ-007 SHALL have port csr_rdata  out  XLEN  read data, combinational from csr_raddr.
REQ-008 SHALL have port csr_rillegal  out  1  csr_raddr is not implemented.
REQ-009 SHALL have ports csr_waddr in 12, csr_wdata in XLEN, csr_wvalid in 1: committed write, one per cycle.
REQ-010 SHALL have port instret_i  in  1  one instruction retired this cycle.
REQ-011 SHALL have ports trap_valid_i in 1, trap_cause_i in XLEN, trap_pc_i in XLEN, trap_tval_i in XLEN: trap taken at commit.
REQ-012 SHALL have port mret_valid_i  in  1  mret retired this cycle.
REQ-013 SHALL have ports mtvec_o out XLEN, mepc_o out XLEN, mie_global_o out 1 (mstatus.MIE).

Function
REQ-014 SHALL implement: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, minstret 0xB02, cycle 0xC00, instret 0xC02, mhartid 0xF14.
REQ-015 SHALL return 0 on csr_rdata and assert csr_rillegal for any other read address; csr_rillegal SHALL be 0 for implemented addresses.
REQ-016 SHALL perform reads with zero latency and no forwarding: a read coinciding with a write to the same address returns the pre-write value.
REQ-017 SHALL apply a write at the clk edge ending the cycle in which csr_wvalid=1; visible to reads from the next cycle.
REQ-018 SHALL silently ignore writes to misa, cycle, instret, mhartid and unimplemented addresses (no state change).
REQ-019 SHALL hold only mstatus bits MIE[3], MPIE[7], MPP[12:11]; MPP reads 2'b11 always and is not writable; all other mstatus bits read 0.
REQ-020 SHALL force mtvec bit 1 to 0 on write (modes 0/1 only) and mepc bits [1:0] to 0 on write and on trap capture.
REQ-021 SHALL store mie, mscratch, mcause, mtval at full XLEN without masking.
REQ-022 SHALL increment mcycle by 1 every cycle out of reset, wrapping 2^XLEN-1 -> 0.
REQ-023 SHALL increment minstret by 1 in each cycle with instret_i=1, wrapping 2^XLEN-1 -> 0.
REQ-024 SHALL, when a write to mcycle/minstret coincides with its increment, load csr_wdata exactly and suppress that cycle's increment.
REQ-025 SHALL read cycle/instret as mcycle/minstret values.
REQ-026 SHALL on trap_valid_i=1: mepc<=trap_pc_i, mcause<=trap_cause_i, mtval<=trap_tval_i, MPIE<=MIE, MIE<=0.
REQ-027 SHALL on mret_valid_i=1 (no trap): MIE<=MPIE, MPIE<=1.
REQ-028 SHALL give trap priority over mret when both asserted in one cycle; the mret is dropped.
REQ-029 SHALL give trap/mret updates priority over a coincident csr write to mstatus, mepc, mcause, mtval; a coincident write to any other CSR SHALL still apply.
REQ-030 SHALL drive mtvec_o, mepc_o, mie_global_o directly from register state (registered, no combinational path from inputs).

Reset
REQ-031 SHALL, while rst=1, immediately force: mstatus MIE=0, MPIE=0; mie, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret = 0.
REQ-032 SHALL ignore all writes, traps, mret and increments while rst=1; mcycle reads 0 in the first cycle after deassertion and 1 in the next.
REQ-033 SHALL abort a coincident write/trap on mid-operation reset assertion; no partial update survives.

Verification
REQ-034 Write 0x305 wdata=0xFFF -> next cycle read 0x305 = 0xFFD, mtvec_o = 0xFFD.
REQ-035 Read 0x7C0 -> csr_rdata=0, csr_rillegal=1; write 0xF14 wdata=5 -> mhartid still reads HART_ID.
REQ-036 Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> next cycle reads all-ones, following cycle reads 0; instret_i=1 with write minstret=0x10 -> minstret=0x10.
REQ-037 MIE=1, trap_valid_i with pc=0x8000_0006, cause=11 plus write mepc=0x40 same cycle -> mepc=0x8000_0004, mcause=11, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
REQ-038 trap_valid_i and mret_valid_i together with MIE=1 -> trap state only (MIE=0, MPIE=1); write mscratch=0xAB same cycle -> mscratch=0xAB.
REQ-039 Assert rst asynchronously between edges during csr_wvalid to mscratch -> all CSRs at reset values, mscratch=0.
